// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked multi-cycle ALU: op codes, FSM states
// and the helper that picks the iterative datapath.
package alu_pkg;

   localparam logic [3:0] ALU_SLL   = 4'h0;
   localparam logic [3:0] ALU_SRL   = 4'h1;
   localparam logic [3:0] ALU_ADD   = 4'h2;
   localparam logic [3:0] ALU_AND   = 4'h3;
   localparam logic [3:0] ALU_OR    = 4'h4;
   localparam logic [3:0] ALU_XOR   = 4'h5;
   localparam logic [3:0] ALU_SLTU  = 4'h6;
   localparam logic [3:0] ALU_MUL   = 4'h7;
   localparam logic [3:0] ALU_MULHU = 4'h8;
   localparam logic [3:0] ALU_DIVU  = 4'h9;
   localparam logic [3:0] ALU_REMU  = 4'hA;
   localparam logic [3:0] ALU_SUB   = 4'hB;
   localparam logic [3:0] ALU_SRA   = 4'hC;
   localparam logic [3:0] ALU_SLT   = 4'hD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Radix-2 iterative multiplier / restoring divider sharing one 2*WIDTH accumulator.
// Mul leaves {hi,lo} = product; div leaves hi = remainder, lo = quotient.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q;
   logic               div_q;
   logic               busy_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shrem;
   logic [WIDTH-1:0]   rem_sub;
   logic               ge;

   always_comb begin
      sum     = '0;
      shrem   = '0;
      rem_sub = '0;
      ge      = 1'b0;
      acc_d   = acc_q;
      if (div_q) begin
         // Divisor 0 always compares ge, giving all-ones quotient and remainder = x.
         shrem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
         ge      = (shrem >= {1'b0, m_q});
         rem_sub = shrem[WIDTH-1:0] - m_q;
         if (ge) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
         else    acc_d = {shrem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end
   end

   assign done_o = busy_q && (cnt_q == CNT_W'(WIDTH-1));
   // Final value is taken from acc_d so the top can retire on the last iteration edge.
   assign lo_o   = acc_d[WIDTH-1:0];
   assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         m_q    <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start_i) begin
         acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
         m_q    <= div_i ? b_i : a_i;
         div_q  <= div_i;
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked execute-stage ALU: single-cycle logic/shift/add/compare path plus
// an iterative mul/div unit, with registered, held outputs.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             equal,
   output logic             illegal
);

   state_e           state_q, state_d;
   logic [3:0]       op_q;
   logic             eq_q;
   logic [WIDTH-1:0] result_q, result_d;
   logic             equal_q, equal_d;
   logic             illegal_q, illegal_d;

   logic             accept;
   logic             start;
   logic [WIDTH-1:0] fast_res;
   logic             fast_ill;
   logic [SHAMT_W-1:0] shamt;

   logic             md_done;
   logic [WIDTH-1:0] md_lo, md_hi;

   assign shamt = y[SHAMT_W-1:0];

   always_comb begin
      fast_res = '0;
      fast_ill = 1'b0;
      case (op)
         ALU_SLL:  fast_res = x << shamt;
         ALU_SRL:  fast_res = x >> shamt;
         ALU_ADD:  fast_res = x + y;
         ALU_AND:  fast_res = x & y;
         ALU_OR:   fast_res = x | y;
         ALU_XOR:  fast_res = x ^ y;
         ALU_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (x < y)};
         ALU_SUB:  fast_res = x - y;
         ALU_SRA:  fast_res = WIDTH'($signed(x) >>> shamt);
         ALU_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         default:  fast_ill = !is_multicycle(op);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      start     = 1'b0;
      result_d  = result_q;
      equal_d   = equal_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: in_ready = 1'b1;
         BUSY: begin
            if (md_done) begin
               state_d   = DONE;
               result_d  = (op_q == ALU_MUL || op_q == ALU_DIVU) ? md_lo : md_hi;
               equal_d   = eq_q;
               illegal_d = 1'b0;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Accepting in DONE retires the held result and launches the next op together.
      accept = in_valid && in_ready;
      if (accept) begin
         if (is_multicycle(op)) begin
            state_d = BUSY;
            start   = 1'b1;
         end else begin
            state_d   = DONE;
            result_d  = fast_res;
            equal_d   = (x == y);
            illegal_d = fast_ill;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= '0;
         eq_q      <= 1'b0;
         result_q  <= '0;
         equal_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         equal_q   <= equal_d;
         illegal_q <= illegal_d;
         if (accept) begin
            op_q <= op;
            eq_q <= (x == y);
         end
      end
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk_i   (clk),
      .rst_i   (reset),
      .start_i (start),
      .div_i   ((op == ALU_DIVU) || (op == ALU_REMU)),
      .a_i     (x),
      .b_i     (y),
      .done_o  (md_done),
      .lo_o    (md_lo),
      .hi_o    (md_hi)
   );

   assign result  = result_q;
   assign equal   = equal_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32): latency, results, handshake, hold and reset abort.
module tb_alu_multicycle;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] x, y;
   logic [3:0]  op;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        equal, illegal;

   int errs = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .equal     (equal),
      .illegal   (illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op from IDLE, measure accept-to-out_valid latency, check outputs,
   // optionally retire it.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee,
                         input logic ei, input int elat, input bit retire);
      int lat;
      @(negedge clk);
      check({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
      op = o; x = a; y = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = $urandom; y = $urandom; op = ALU_SUB;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(elat));
      check({tag, ".res"}, result, er);
      check({tag, ".eq"},  {31'd0, equal}, {31'd0, ee});
      check({tag, ".ill"}, {31'd0, illegal}, {31'd0, ei});
      if (retire) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   logic [31:0] bb_a [4] = '{32'h1, 32'hA, 32'hFFFFFFFF, 32'h7FFFFFFF};
   logic [31:0] bb_b [4] = '{32'h1, 32'h14, 32'h2, 32'h1};
   logic [31:0] bb_r [4] = '{32'h2, 32'h1E, 32'h1, 32'h80000000};

   initial begin
      bit seen;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; y = '0; op = '0;
      #1;
      check("rst.ov",  {31'd0, out_valid}, 32'd0);
      check("rst.res", result, 32'd0);
      check("rst.eq",  {31'd0, equal}, 32'd0);
      check("rst.ill", {31'd0, illegal}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst.rdy", {31'd0, in_ready}, 32'd1);

      run_op("add_ovf", ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1, 1'b1);

      // Back-to-back: out_ready held high, one ADD accepted every cycle.
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op = ALU_ADD; x = bb_a[i]; y = bb_b[i]; in_valid = 1'b1;
         #1 check($sformatf("b2b%0d.rdy", i), {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         check($sformatf("b2b%0d.ov", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("b2b%0d.res", i), result, bb_r[i]);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b.retired", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      run_op("mulhu", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 33, 1'b1);
      run_op("mul",   ALU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 33, 1'b1);
      run_op("divu",  ALU_DIVU,  32'h64, 32'h7, 32'hE, 1'b0, 1'b0, 33, 1'b1);
      run_op("remu",  ALU_REMU,  32'h64, 32'h7, 32'h2, 1'b0, 1'b0, 33, 1'b1);
      run_op("div0",  ALU_DIVU,  32'h5, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 1'b1);
      run_op("rem0",  ALU_REMU,  32'h5, 32'h0, 32'h5, 1'b0, 1'b0, 33, 1'b1);

      run_op("sra",   ALU_SRA,  32'h80000000, 32'h0000011F, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 1'b1);
      run_op("slt",   ALU_SLT,  32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1, 1'b1);
      run_op("sltu",  ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1, 1'b1);
      run_op("and_eq", ALU_AND, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0, 1, 1'b1);
      run_op("sll",   ALU_SLL,  32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 1, 1'b1);
      run_op("srl",   ALU_SRL,  32'h80000000, 32'h4, 32'h08000000, 1'b0, 1'b0, 1, 1'b1);
      run_op("sub",   ALU_SUB,  32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 1'b1);
      run_op("or",    ALU_OR,   32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1, 1'b1);

      // Held result: a pending request must not overwrite or retire it.
      run_op("xor", ALU_XOR, 32'h12345678, 32'h0000FFFF, 32'h1234A987, 1'b0, 1'b0, 1, 1'b0);
      op = ALU_ADD; x = 32'h1; y = 32'h1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d.ov", i),  {31'd0, out_valid}, 32'd1);
         check($sformatf("hold%0d.res", i), result, 32'h1234A987);
         check($sformatf("hold%0d.rdy", i), {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      run_op("illegal", 4'hF, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1, 1'b1);
      run_op("legal_after", ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1, 1'b1);

      // Abort a DIVU in flight with reset.
      @(negedge clk);
      op = ALU_DIVU; x = 32'h64; y = 32'h7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort.ov",  {31'd0, out_valid}, 32'd0);
      check("abort.res", result, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("abort.rdy", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort.no_ov", {31'd0, seen}, 32'd0);
      run_op("add_post", ALU_ADD, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
